// File: rtl/capture_ctrl_if.sv
// Control and status bundle between the capture controller, its host and the
// channel sampler / capture RAM.
interface capture_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              run;
  logic              stop;
  logic [3:0]        decimator;
  logic [ADDR_W-1:0] trig_pos;
  logic              trigger;
  logic              clr_done;
  logic              smpl_en;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              capture_done;
  logic              busy;

  modport master (
    output run, stop, decimator, trig_pos, trigger, clr_done,
    input  smpl_en, we, waddr, trig_addr, armed, capture_done, busy
  );

  modport slave (
    input  run, stop, decimator, trig_pos, trigger, clr_done,
    output smpl_en, we, waddr, trig_addr, armed, capture_done, busy
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: decimated sample strobes, circular pre-trigger buffering,
// trigger address latch and post-trigger sample countdown.
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input logic           clk,
  input logic           rst_n,
  capture_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRE       = 3'd1;
  localparam logic [2:0] WAIT_TRIG = 3'd2;
  localparam logic [2:0] POST      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state, state_n;
  logic [3:0]        dec_q, dec_n;
  logic [ADDR_W-1:0] tpos_q, tpos_n;
  logic [14:0]       cnt, cnt_n;
  logic [ADDR_W:0]   wcnt, wcnt_n;
  logic [ADDR_W-1:0] pcnt, pcnt_n;
  logic [ADDR_W-1:0] waddr_n, taddr_n;
  logic              active, active_n, wr, strobe_n;

  function automatic logic [14:0] period_max(input logic [3:0] d);
    return 15'((16'd1 << d) - 16'd1);
  endfunction

  always_comb begin
    state_n = state;
    dec_n   = dec_q;
    tpos_n  = tpos_q;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    pcnt_n  = pcnt;
    waddr_n = bus.waddr;
    taddr_n = bus.trig_addr;
    active  = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    wr      = active && bus.we;

    if (bus.stop) begin
      state_n = IDLE;
    end else if (bus.run && ((state == IDLE) || (state == DONE))) begin
      state_n = PRE;
      dec_n   = bus.decimator;
      tpos_n  = bus.trig_pos;
      cnt_n   = '0;
      wcnt_n  = '0;
      waddr_n = '0;
    end else begin
      if (active) cnt_n = (cnt == period_max(dec_q)) ? '0 : cnt + 15'd1;
      if (wr) waddr_n = bus.waddr + ADDR_W'(1);
      case (state)
        PRE: begin
          if (wr) begin
            wcnt_n = wcnt + (ADDR_W+1)'(1);
            if (wcnt_n == DEPTH - {1'b0, tpos_q}) state_n = WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          // A write coinciding with the trigger is already post-sample 1.
          if (bus.trigger) begin
            taddr_n = bus.waddr;
            pcnt_n  = wr ? tpos_q - ADDR_W'(1) : tpos_q;
            if ((tpos_q == '0) || (wr && (tpos_q == ADDR_W'(1)))) state_n = DONE;
            else state_n = POST;
          end
        end
        POST: begin
          if (wr) begin
            pcnt_n = pcnt - ADDR_W'(1);
            if (pcnt == ADDR_W'(1)) state_n = DONE;
          end
        end
        DONE: begin
          if (bus.clr_done) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    active_n = (state_n == PRE) || (state_n == WAIT_TRIG) || (state_n == POST);
    // Strobes are registered, so they are decided from the next counter value.
    strobe_n = active_n && (cnt_n == period_max(dec_n));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      dec_q            <= '0;
      tpos_q           <= '0;
      cnt              <= '0;
      wcnt             <= '0;
      pcnt             <= '0;
      bus.smpl_en      <= 1'b0;
      bus.we           <= 1'b0;
      bus.waddr        <= '0;
      bus.trig_addr    <= '0;
      bus.armed        <= 1'b0;
      bus.capture_done <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      state            <= state_n;
      dec_q            <= dec_n;
      tpos_q           <= tpos_n;
      cnt              <= cnt_n;
      wcnt             <= wcnt_n;
      pcnt             <= pcnt_n;
      bus.smpl_en      <= strobe_n;
      bus.we           <= strobe_n;
      bus.waddr        <= waddr_n;
      bus.trig_addr    <= taddr_n;
      bus.armed        <= (state_n == WAIT_TRIG);
      bus.capture_done <= (state_n == DONE);
      bus.busy         <= active_n;
    end
  end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter: ADDR_W, default 9, capture RAM address width; depth DEPTH = 2^ADDR_W.
REQ-003 Port: clk  in  1  system clock; all state updates on posedge clk.
REQ-004 Port: rst_n  in  1  synchronous active-low reset.
REQ-005 Port: run  in  1  single-cycle pulse that starts a capture.
REQ-006 Port: stop  in  1  abort; returns the block to IDLE.
REQ-007 Port: decimator  in  4  sample period = 2^decimator clk cycles.
REQ-008 Port: trig_pos  in  ADDR_W  number of post-trigger samples.
REQ-009 Port: trigger  in  1  synchronous trigger event from the trigger logic.
REQ-010 Port: clr_done  in  1  acknowledges and clears capture_done.
REQ-011 Port: smpl_en  out  1  one-cycle sample strobe to the channel sampler.
REQ-012 Port: we  out  1  capture RAM write enable.
REQ-013 Port: waddr  out  ADDR_W  capture RAM write address.
REQ-014 Port: trig_addr  out  ADDR_W  RAM address of the first post-trigger sample.
REQ-015 Port: armed  out  1  pre-trigger buffer full; trigger accepted.
REQ-016 Port: capture_done  out  1  capture complete; RAM contents stable.
REQ-017 Port: busy  out  1  high in PRE, WAIT_TRIG and POST.

Function
REQ-018 States SHALL be IDLE, PRE, WAIT_TRIG, POST and DONE; all outputs SHALL be registered.
REQ-019 IDLE or DONE + run SHALL enter PRE and clear waddr, sample count, decimation counter and capture_done; decimator and trig_pos SHALL be latched at that edge.
REQ-020 Changes to decimator or trig_pos after run SHALL have no effect until the next run.
REQ-021 In PRE, WAIT_TRIG and POST, a 15-bit decimation counter SHALL count from 0 to 2^decimator-1 and then wrap to 0.
REQ-022 smpl_en and we SHALL both be high for exactly the one cycle in which the counter equals 2^decimator-1. The first strobe SHALL therefore occur 2^decimator cycles after the run edge.
REQ-023 waddr SHALL hold the address being written while we=1, and SHALL increment on the following edge. It SHALL wrap from DEPTH-1 to 0.
REQ-024 PRE SHALL count writes. The write that makes the count equal DEPTH-trig_pos SHALL move the state to WAIT_TRIG.
REQ-025 armed SHALL be 1 only in WAIT_TRIG.
REQ-026 In WAIT_TRIG, writes SHALL continue circularly. trigger=1 SHALL latch trig_addr <= waddr, so a write and the trigger in the same cycle yields that write's address.
REQ-027 The trigger event in REQ-026 SHALL load the post counter with the latched trig_pos. The next state SHALL be POST if trig_pos != 0, and DONE if trig_pos = 0.
REQ-028 The write in the trigger cycle SHALL count as post-trigger sample 1 when in POST.
REQ-029 In POST, each write SHALL decrement the post counter. The write that reaches 0 SHALL be the last write, and the state SHALL move to DONE on the next edge.
REQ-030 In DONE: capture_done=1, and smpl_en, we and busy SHALL be 0. waddr and trig_addr SHALL hold.
REQ-031 clr_done in DONE SHALL return the block to IDLE with capture_done=0.
REQ-032 trigger outside WAIT_TRIG SHALL be ignored; this includes the cycle in which PRE completes.
REQ-033 run in PRE, WAIT_TRIG or POST SHALL be ignored.
REQ-034 stop SHALL return the block to IDLE from any state on the next edge, with smpl_en=we=0 and capture_done=0.
REQ-035 Priority SHALL be stop > run > trigger > clr_done.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE, smpl_en=0, we=0, waddr=0, trig_addr=0, armed=0, capture_done=0, busy=0, and clear all counters.
REQ-037 Reset SHALL have this effect in any state, including mid-capture.
REQ-038 Reset SHALL take priority over all inputs.

Verification
REQ-039 Reset: assert rst_n=0 during POST -> all outputs 0 and IDLE next cycle; run afterwards starts cleanly.
REQ-040 Decimation: decimator=2, run -> smpl_en/we high 1 cycle in 4, first at cycle 4 after run; waddr 0,1,2... wraps 511->0.
REQ-041 Arming: decimator=0, trig_pos=256, run -> armed rises after the 256th write (waddr=256); trigger pulses before that are ignored.
REQ-042 Post-trigger: from REQ-041, trigger at waddr=300 -> trig_addr=300; writes 300..555 mod 512 (256 total); capture_done=1, we=0; clr_done -> IDLE.
REQ-043 trig_pos=0: 512 pre writes, then armed; trigger -> DONE next cycle, no further writes, trig_addr=waddr at trigger.
REQ-044 Priority: stop and trigger in the same WAIT_TRIG cycle -> IDLE, trig_addr unchanged; run during POST ignored.
